// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 set-2 to ASCII decoder: FSM states, protocol bytes
// and the ASCII constants used by the scancode ROM.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Controller status/response bytes that never represent a key.
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_BS      = 8'h08;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  function automatic logic is_ignored(input logic [7:0] c);
    return (c == SC_BAT_OK) || (c == SC_ACK) || (c == SC_ECHO) ||
           (c == SC_ERR0) || (c == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_scancode_rom.sv
// Combinational set-2 scancode to ASCII lookup; letters take their case from upper_i.
// Unmapped codes return 8'h00.
module ps2_scancode_rom
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       upper_i,
  output logic [7:0] ascii_o
);

  logic [7:0] base;
  assign base = upper_i ? ASCII_UPPER_A : ASCII_LOWER_A;

  always_comb begin
    ascii_o = 8'h00;
    case (code_i)
      8'h1C: ascii_o = base + 8'd0;   8'h32: ascii_o = base + 8'd1;
      8'h21: ascii_o = base + 8'd2;   8'h23: ascii_o = base + 8'd3;
      8'h24: ascii_o = base + 8'd4;   8'h2B: ascii_o = base + 8'd5;
      8'h34: ascii_o = base + 8'd6;   8'h33: ascii_o = base + 8'd7;
      8'h43: ascii_o = base + 8'd8;   8'h3B: ascii_o = base + 8'd9;
      8'h42: ascii_o = base + 8'd10;  8'h4B: ascii_o = base + 8'd11;
      8'h3A: ascii_o = base + 8'd12;  8'h31: ascii_o = base + 8'd13;
      8'h44: ascii_o = base + 8'd14;  8'h4D: ascii_o = base + 8'd15;
      8'h15: ascii_o = base + 8'd16;  8'h2D: ascii_o = base + 8'd17;
      8'h1B: ascii_o = base + 8'd18;  8'h2C: ascii_o = base + 8'd19;
      8'h3C: ascii_o = base + 8'd20;  8'h2A: ascii_o = base + 8'd21;
      8'h1D: ascii_o = base + 8'd22;  8'h22: ascii_o = base + 8'd23;
      8'h35: ascii_o = base + 8'd24;  8'h1A: ascii_o = base + 8'd25;
      8'h45: ascii_o = ASCII_ZERO + 8'd0;  8'h16: ascii_o = ASCII_ZERO + 8'd1;
      8'h1E: ascii_o = ASCII_ZERO + 8'd2;  8'h26: ascii_o = ASCII_ZERO + 8'd3;
      8'h25: ascii_o = ASCII_ZERO + 8'd4;  8'h2E: ascii_o = ASCII_ZERO + 8'd5;
      8'h36: ascii_o = ASCII_ZERO + 8'd6;  8'h3D: ascii_o = ASCII_ZERO + 8'd7;
      8'h3E: ascii_o = ASCII_ZERO + 8'd8;  8'h46: ascii_o = ASCII_ZERO + 8'd9;
      8'h29: ascii_o = ASCII_SPACE;
      8'h5A: ascii_o = ASCII_CR;
      8'h66: ascii_o = ASCII_BS;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 byte stream to case-correct ASCII with make/break/extended FSM,
// Shift/CapsLock tracking and a first-word-fall-through output FIFO.
module ps2_ascii_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned REPEAT_EN  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          code_valid,
  input  logic [7:0]                    code,
  output logic                          ascii_valid,
  output logic [7:0]                    ascii_data,
  input  logic                          ascii_ready,
  output logic                          key_down,
  output logic [7:0]                    held_code,
  output logic                          shift_on,
  output logic                          caps_on,
  output logic [CNT_W-1:0]              press_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output ps2_state_e                    dbg_state
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  ps2_state_e       state_q;
  logic [7:0]       held_q;
  logic             shl_q, shr_q, caps_q, caps_held_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic       is_make, is_mod, key_make, new_key, push_req;
  logic       full, empty, push, pop;
  logic [7:0] rom_ascii;

  // Case is decided from the registered modifier state, before this byte lands.
  ps2_scancode_rom u_rom (
    .code_i  (code),
    .upper_i ((shl_q | shr_q) ^ caps_q),
    .ascii_o (rom_ascii)
  );

  assign is_make  = code_valid && (state_q == ST_IDLE) && (code != SC_BREAK) &&
                    (code != SC_EXT) && !is_ignored(code);
  assign is_mod   = (code == SC_LSHIFT) || (code == SC_RSHIFT) || (code == SC_CAPS);
  assign key_make = is_make && !is_mod;
  assign new_key  = (code != held_q);
  assign push_req = key_make && (rom_ascii != 8'h00) && ((REPEAT_EN != 0) || new_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      held_q      <= 8'h00;
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      cnt_q       <= '0;
    end else if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code == SC_BREAK)   state_q <= ST_BRK;
          else if (code == SC_EXT) state_q <= ST_EXT;
          else if (!is_ignored(code)) begin
            case (code)
              SC_LSHIFT: shl_q <= 1'b1;
              SC_RSHIFT: shr_q <= 1'b1;
              SC_CAPS: begin
                if (!caps_held_q) caps_q <= ~caps_q;
                caps_held_q <= 1'b1;
              end
              default: begin
                if (new_key) begin
                  held_q <= code;
                  cnt_q  <= cnt_q + CNT_W'(1);
                end
              end
            endcase
          end
        end
        ST_BRK: begin
          state_q <= ST_IDLE;
          // A prefix byte after F0 is a protocol error and is simply dropped.
          if ((code != SC_BREAK) && (code != SC_EXT)) begin
            case (code)
              SC_LSHIFT: shl_q <= 1'b0;
              SC_RSHIFT: shr_q <= 1'b0;
              SC_CAPS:   caps_held_q <= 1'b0;
              default:   if (code == held_q) held_q <= 8'h00;
            endcase
          end
        end
        ST_EXT:     state_q <= (code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && ascii_ready;
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && full && !pop) ovf_q <= 1'b1;
      else if (ovf_clr)             ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rom_ascii;
  end

  assign ascii_valid = !empty;
  assign ascii_data  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level  = wr_ptr_q - rd_ptr_q;
  assign overflow    = ovf_q;
  assign key_down    = (held_q != 8'h00);
  assign held_code   = held_q;
  assign shift_on    = shl_q | shr_q;
  assign caps_on     = caps_q;
  assign press_count = cnt_q;
  assign dbg_state   = state_q;

endmodule
